// File: rtl/traffic_phase_ctrl_n_pkg.sv
// Shared definitions for the density-based traffic phase controller:
// phase encoding and default timing constants (all timing in TICKs).
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_ORANGE = 2'd2
  } phase_e;

  localparam int DEF_N_SIDES   = 4;
  localparam int DEF_GREEN_MIN = 10;
  localparam int DEF_GREEN_MAX = 30;
  localparam int DEF_EXT_STEP  = 5;
  localparam int DEF_ORANGE_T  = 3;
  localparam int DEF_ALLRED_T  = 2;

endpackage

// File: rtl/traffic_phase_ctrl_n_if.sv
// Signal bundle between the timing source / sensors and the phase controller.
// master: drives TICK and DEMAND; slave: the controller, drives lamps and display.
interface traffic_phase_ctrl_n_if #(
  parameter int N_SIDES   = 4,
  parameter int GREEN_MAX = 30
);
  localparam int SW = $clog2(N_SIDES);
  localparam int TW = $clog2(GREEN_MAX + 1);

  logic               TICK;
  logic [N_SIDES-1:0] DEMAND;
  logic [N_SIDES-1:0] RED;
  logic [N_SIDES-1:0] GREEN;
  logic [N_SIDES-1:0] ORANGE;
  logic [SW-1:0]      SIDE;
  logic [TW-1:0]      TIME;
  logic               NEXT;

  modport master (
    output TICK, DEMAND,
    input  RED, GREEN, ORANGE, SIDE, TIME, NEXT
  );

  modport slave (
    input  TICK, DEMAND,
    output RED, GREEN, ORANGE, SIDE, TIME, NEXT
  );

endinterface

// File: rtl/traffic_phase_ctrl_n_rr_next_side.sv
// Combinational side selection: rotating priority search after the current
// side (current side excluded), plus the lowest demanding side for start-up.
module rr_next_side #(
  parameter int N_SIDES = 4,
  parameter int SW      = $clog2(N_SIDES)
) (
  input  logic [N_SIDES-1:0] demand,
  input  logic [SW-1:0]      side,
  output logic [SW-1:0]      next_side,
  output logic               any_other,
  output logic [SW-1:0]      first_idx
);

  // Rotate-search after side; wrap by compare so SIDE never leaves 0..N_SIDES-1.
  always_comb begin
    int idx_s;
    idx_s = 0;
    any_other = 1'b0;
    if (int'(side) >= N_SIDES - 1) begin
      next_side = '0;
    end else begin
      next_side = side + SW'(1);
    end
    for (int k = 1; k < N_SIDES; k++) begin
      idx_s = int'(side) + k;
      if (idx_s >= N_SIDES) begin
        idx_s = idx_s - N_SIDES;
      end else begin
        idx_s = idx_s;
      end
      if (!any_other && demand[idx_s]) begin
        any_other = 1'b1;
        next_side = SW'(idx_s);
      end else begin
        any_other = any_other;
      end
    end
  end

  // Lowest-numbered demanding side; side 0 when nobody is waiting.
  always_comb begin
    first_idx = '0;
    for (int k = N_SIDES - 1; k >= 0; k--) begin
      if (demand[k]) begin
        first_idx = SW'(k);
      end else begin
        first_idx = first_idx;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl_n.sv
// Density-based phase controller for N approaches. Round-robin green among
// demanding sides, green extension while the holder still has demand (capped),
// rest-in-green when nobody else waits. Lamps, SIDE, TIME and NEXT are registered.
module traffic_phase_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_SIDES   = DEF_N_SIDES,
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int EXT_STEP  = DEF_EXT_STEP,
  parameter int ORANGE_T  = DEF_ORANGE_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input logic                   CLK_100MHZ,
  input logic                   RESET,
  traffic_phase_ctrl_n_if.slave bus
);

  localparam int SW = $clog2(N_SIDES);
  localparam int TW = $clog2(GREEN_MAX + 1);

  phase_e             state_r, state_n_s;
  logic [SW-1:0]      side_r, side_n_s;
  logic [TW-1:0]      time_r, time_n_s;
  logic [TW-1:0]      elapsed_r, elapsed_n_s, elapsed_tick_s;
  logic               next_n_s;
  logic               ext_ok_s;
  logic [N_SIDES-1:0] green_n_s, orange_n_s;
  logic [N_SIDES-1:0] red_r, green_r, orange_r;
  logic               next_r;

  logic [SW-1:0]      rr_next_s, rr_first_s;
  logic               rr_any_other_s;

  rr_next_side #(.N_SIDES(N_SIDES), .SW(SW)) u_rr (
    .demand    (bus.DEMAND),
    .side      (side_r),
    .next_side (rr_next_s),
    .any_other (rr_any_other_s),
    .first_idx (rr_first_s)
  );

  // Green ticks served including the current tick (saturating), and whether
  // one more extension still stays strictly under the green cap.
  always_comb begin
    if (elapsed_r >= TW'(GREEN_MAX)) begin
      elapsed_tick_s = TW'(GREEN_MAX);
    end else begin
      elapsed_tick_s = elapsed_r + TW'(1);
    end
    ext_ok_s = (({1'b0, elapsed_tick_s} + (TW+1)'(EXT_STEP)) < (TW+1)'(GREEN_MAX));
  end

  // Phase sequencing: everything advances only on TICK; a phase ends on the TICK where TIME==1.
  always_comb begin
    state_n_s   = state_r;
    side_n_s    = side_r;
    time_n_s    = time_r;
    elapsed_n_s = elapsed_r;
    next_n_s    = 1'b0;
    if (bus.TICK) begin
      case (state_r)
        ST_ALLRED: begin
          if (time_r == TW'(1)) begin
            state_n_s   = ST_GREEN;
            side_n_s    = rr_first_s;
            time_n_s    = TW'(GREEN_MIN);
            elapsed_n_s = '0;
            next_n_s    = 1'b1;
          end else begin
            time_n_s = time_r - TW'(1);
          end
        end
        ST_GREEN: begin
          elapsed_n_s = elapsed_tick_s;
          if (time_r == TW'(1)) begin
            if (bus.DEMAND[side_r] && ext_ok_s) begin
              time_n_s = TW'(EXT_STEP);
            end else if (rr_any_other_s) begin
              state_n_s = ST_ORANGE;
              time_n_s  = TW'(ORANGE_T);
            end else begin
              // Nobody else waiting: rest in green with a fresh allowance.
              time_n_s    = TW'(GREEN_MIN);
              elapsed_n_s = '0;
            end
          end else begin
            time_n_s = time_r - TW'(1);
          end
        end
        ST_ORANGE: begin
          if (time_r == TW'(1)) begin
            state_n_s   = ST_GREEN;
            side_n_s    = rr_next_s;
            time_n_s    = TW'(GREEN_MIN);
            elapsed_n_s = '0;
            next_n_s    = 1'b1;
          end else begin
            time_n_s = time_r - TW'(1);
          end
        end
        default: begin
          state_n_s   = ST_ALLRED;
          side_n_s    = '0;
          time_n_s    = TW'(ALLRED_T);
          elapsed_n_s = '0;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Lamp decode from the next phase and side so lamps change with the state register.
  always_comb begin
    green_n_s  = '0;
    orange_n_s = '0;
    if (state_n_s == ST_GREEN) begin
      green_n_s = {{(N_SIDES-1){1'b0}}, 1'b1} << side_n_s;
    end else if (state_n_s == ST_ORANGE) begin
      orange_n_s = {{(N_SIDES-1){1'b0}}, 1'b1} << side_n_s;
    end else begin
      green_n_s = '0;
    end
  end

  // State, counters and registered outputs; RESET has priority over TICK.
  always_ff @(posedge CLK_100MHZ) begin
    if (RESET) begin
      state_r   <= ST_ALLRED;
      side_r    <= '0;
      time_r    <= TW'(ALLRED_T);
      elapsed_r <= '0;
      red_r     <= '1;
      green_r   <= '0;
      orange_r  <= '0;
      next_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      side_r    <= side_n_s;
      time_r    <= time_n_s;
      elapsed_r <= elapsed_n_s;
      red_r     <= ~(green_n_s | orange_n_s);
      green_r   <= green_n_s;
      orange_r  <= orange_n_s;
      next_r    <= next_n_s;
    end
  end

  assign bus.RED    = red_r;
  assign bus.GREEN  = green_r;
  assign bus.ORANGE = orange_r;
  assign bus.SIDE   = side_r;
  assign bus.TIME   = time_r;
  assign bus.NEXT   = next_r;

endmodule

// File: tb/tb_traffic_phase_ctrl_n.sv
// Bench for traffic_phase_ctrl_n: a 4-side and a 3-side instance share clock,
// reset and TICK; a tick-level behavioural model is compared every cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_traffic_phase_ctrl_n;

  localparam int P_AR = 0;
  localparam int P_G  = 1;
  localparam int P_O  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] demand_a;
  logic [2:0] demand_b;

  int n_total = 0;
  int n_pass  = 0;

  int  m_ph [2];
  int  m_sd [2];
  int  m_tm [2];
  int  m_el [2];
  bit  m_nx [2];
  bit  m_valid = 1'b0;

  int nexts_a    = 0;
  int oranges_a  = 0;
  int side_b_max = 0;
  int glen;

  always #5 clk = ~clk;

  traffic_phase_ctrl_n_if #(.N_SIDES(4), .GREEN_MAX(30)) bus_a ();
  traffic_phase_ctrl_n_if #(.N_SIDES(3), .GREEN_MAX(30)) bus_b ();

  assign bus_a.TICK   = tick;
  assign bus_a.DEMAND = demand_a;
  assign bus_b.TICK   = tick;
  assign bus_b.DEMAND = demand_b;

  traffic_phase_ctrl_n #(.N_SIDES(4), .GREEN_MIN(10), .GREEN_MAX(30), .EXT_STEP(5),
                         .ORANGE_T(3), .ALLRED_T(2)) dut_a (
    .CLK_100MHZ (clk),
    .RESET      (rst),
    .bus        (bus_a.slave)
  );

  traffic_phase_ctrl_n #(.N_SIDES(3), .GREEN_MIN(10), .GREEN_MAX(30), .EXT_STEP(5),
                         .ORANGE_T(3), .ALLRED_T(2)) dut_b (
    .CLK_100MHZ (clk),
    .RESET      (rst),
    .bus        (bus_b.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Tick-level model: one call per clock edge, in terms of remaining time,
  // green served so far and a modular search for the next waiting side.
  task automatic model_step(input int d, input int n, input logic [3:0] dm);
    int cand;
    m_nx[d] = 1'b0;
    if (rst) begin
      m_ph[d] = P_AR; m_sd[d] = 0; m_tm[d] = 2; m_el[d] = 0;
    end else if (tick) begin
      if (m_ph[d] == P_G) m_el[d] = (m_el[d] + 1 > 30) ? 30 : m_el[d] + 1;
      if (m_tm[d] > 1) begin
        m_tm[d]--;
      end else if (m_ph[d] == P_AR) begin
        m_sd[d] = 0;
        for (int i = n - 1; i >= 0; i--) if (dm[i]) m_sd[d] = i;
        m_ph[d] = P_G; m_tm[d] = 10; m_el[d] = 0; m_nx[d] = 1'b1;
      end else if (m_ph[d] == P_G) begin
        cand = -1;
        for (int k = n - 1; k >= 1; k--) if (dm[(m_sd[d] + k) % n]) cand = (m_sd[d] + k) % n;
        if (dm[m_sd[d]] && (m_el[d] + 5 < 30)) begin
          m_tm[d] = 5;
        end else if (cand >= 0) begin
          m_ph[d] = P_O; m_tm[d] = 3;
        end else begin
          m_tm[d] = 10; m_el[d] = 0;
        end
      end else begin
        cand = (m_sd[d] + 1) % n;
        for (int k = n - 1; k >= 1; k--) if (dm[(m_sd[d] + k) % n]) cand = (m_sd[d] + k) % n;
        m_ph[d] = P_G; m_sd[d] = cand; m_tm[d] = 10; m_el[d] = 0; m_nx[d] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, demand_a);
    model_step(1, 3, {1'b0, demand_b});
    if (rst) m_valid = 1'b1;
  end

  task automatic compare_one(input int d, input int n, input logic [3:0] r, input logic [3:0] g,
                             input logic [3:0] o, input int sd, input int tm, input logic nx);
    logic [3:0] eg, eo, er, mask;
    string pfx;
    pfx  = (d == 0) ? "a_" : "b_";
    mask = (n == 4) ? 4'b1111 : 4'b0111;
    eg = 4'b0000;
    eo = 4'b0000;
    if (m_ph[d] == P_G) eg[m_sd[d]] = 1'b1;
    if (m_ph[d] == P_O) eo[m_sd[d]] = 1'b1;
    er = ~(eg | eo) & mask;
    chk({pfx, "red"},    32'(r),  32'(er));
    chk({pfx, "green"},  32'(g),  32'(eg));
    chk({pfx, "orange"}, 32'(o),  32'(eo));
    chk({pfx, "side"},   32'(sd), 32'(m_sd[d]));
    chk({pfx, "time"},   32'(tm), 32'(m_tm[d]));
    chk({pfx, "next"},   32'(nx), 32'(m_nx[d]));
  endtask

  // Every-cycle comparison against the model, plus event bookkeeping.
  always @(negedge clk) begin
    if (m_valid) begin
      compare_one(0, 4, bus_a.RED, bus_a.GREEN, bus_a.ORANGE, int'(bus_a.SIDE), int'(bus_a.TIME), bus_a.NEXT);
      compare_one(1, 3, {1'b0, bus_b.RED}, {1'b0, bus_b.GREEN}, {1'b0, bus_b.ORANGE},
                  int'(bus_b.SIDE), int'(bus_b.TIME), bus_b.NEXT);
      if (bus_a.NEXT === 1'b1) nexts_a++;
      if (bus_a.ORANGE !== 4'b0000) oranges_a++;
      if (int'(bus_b.SIDE) > side_b_max) side_b_max = int'(bus_b.SIDE);
    end
  end

  task automatic do_tick(input int k);
    repeat (k) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; demand_a = 4'b0000; demand_b = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_red",   32'(bus_a.RED),    32'h0000000f);
    chk("rst_green", 32'(bus_a.GREEN),  32'h00000000);
    chk("rst_time",  32'(bus_a.TIME),   32'd2);
    chk("rst_side",  32'(bus_a.SIDE),   32'd0);
    @(posedge clk); #1;

    // No demand: ALLRED expires after 2 ticks onto side 0.
    do_tick(2);
    @(negedge clk);
    chk("start_green", 32'(bus_a.GREEN), 32'h00000001);
    chk("start_time",  32'(bus_a.TIME),  32'd10);
    chk("start_next",  32'(nexts_a),     32'd1);
    @(posedge clk); #1;

    // Sides 1 and 3 wait; side 0 has no demand and hands over after 10 ticks.
    demand_a = 4'b1010;
    demand_b = 3'b100;
    do_tick(10);
    chk("hand_orange", 32'(bus_a.ORANGE), 32'h00000001);
    chk("hand_otime",  32'(bus_a.TIME),   32'd3);
    do_tick(3);
    chk("hand_green1", 32'(bus_a.GREEN),  32'h00000002);
    chk("hand_next",   32'(nexts_a),      32'd2);
    chk("b_skip_to2",  32'(bus_b.SIDE),   32'd2);
    demand_b = 3'b001;

    // Side 1 keeps demanding: 10+5+5+5 green ticks, then orange.
    glen = 0;
    for (int i = 0; i < 40 && bus_a.GREEN[1] === 1'b1; i++) begin
      do_tick(1);
      glen++;
    end
    chk("ext_len",    32'(glen),          32'd25);
    chk("ext_orange", 32'(bus_a.ORANGE),  32'h00000002);
    do_tick(3);
    chk("skip_side3", 32'(bus_a.SIDE),    32'd3);
    chk("skip_green", 32'(bus_a.GREEN),   32'h00000008);
    chk("b_wrap_0",   32'(bus_b.SIDE),    32'd0);

    // Only the holder demands: rests in green, no orange, no new green.
    demand_a = 4'b1000;
    glen = nexts_a;
    oranges_a = 0;
    do_tick(30);
    chk("rest_next",   32'(nexts_a),     32'(glen));
    chk("rest_orange", 32'(oranges_a),   32'd0);
    chk("rest_side",   32'(bus_a.SIDE),  32'd3);
    chk("rest_time",   32'(bus_a.TIME),  32'd5);

    // Side 0 waits, side 3 released: reach orange, then reset together with a TICK.
    demand_a = 4'b0001;
    for (int i = 0; i < 40 && bus_a.ORANGE === 4'b0000; i++) do_tick(1);
    chk("pre_rst_orange", 32'(bus_a.ORANGE), 32'h00000008);
    do_tick(1);
    rst = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    chk("mid_rst_red",    32'(bus_a.RED),    32'h0000000f);
    chk("mid_rst_orange", 32'(bus_a.ORANGE), 32'h00000000);
    chk("mid_rst_time",   32'(bus_a.TIME),   32'd2);
    chk("b_side_range",   32'(side_b_max),   32'd2);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
